// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - state encodings and colour constants for the sprite move engine
package sprite_pkg;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_ERASE,
    S_UPDATE,
    S_DRAW
  } state_t;

  localparam logic [2:0] COLOUR_WHITE = 3'b111;
  localparam logic [2:0] COLOUR_BLACK = 3'b000;

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - free-running frame tick, one-cycle pulse every FRAME_DIV clocks
module frame_tick_gen #(
  parameter int FRAME_DIV = 833333
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= CW'(FRAME_DIV - 1);
    end else if (count == '0) begin
      count <= CW'(FRAME_DIV - 1);
    end else begin
      count <= count - 1'b1;
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/sprite_move_engine.sv
// rtl/sprite_move_engine.sv - clear screen, then erase/move/redraw a rectangular sprite every frame tick
module sprite_move_engine
  import sprite_pkg::*;
#(
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120,
  parameter int         X_W       = 8,
  parameter int         Y_W       = 7,
  parameter int         SPR_W     = 16,
  parameter int         SPR_H     = 2,
  parameter int         START_X   = 76,
  parameter int         START_Y   = 110,
  parameter int         STEP      = 1,
  parameter int         FRAME_DIV = 833333,
  parameter logic [2:0] FG_COLOUR = COLOUR_WHITE,
  parameter logic [2:0] BG_COLOUR = COLOUR_BLACK
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           move_left,
  input  logic           move_right,
  input  logic           move_up,
  input  logic           move_down,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     colour,
  output logic           plot,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           busy,
  output logic           overrun
);

  state_t         state, state_next;
  logic [X_W-1:0] col, col_last;
  logic [Y_W-1:0] row, row_last;
  logic           sweeping, sweep_last;
  logic           frame_tick;

  logic [X_W:0]   right_sum;
  logic [Y_W:0]   down_sum;
  logic [X_W-1:0] pos_x_next;
  logic [Y_W-1:0] pos_y_next;

  logic [X_W-1:0] pix_x_next;
  logic [Y_W-1:0] pix_y_next;
  logic [2:0]     colour_next;
  logic           plot_next;

  frame_tick_gen #(
    .FRAME_DIV(FRAME_DIV)
  ) u_frame_tick (
    .clock(clock),
    .reset(reset),
    .tick (frame_tick)
  );

  // CLEAR sweeps the whole screen; ERASE and DRAW sweep the sprite footprint.
  always_comb begin
    col_last = X_W'(SPR_W - 1);
    row_last = Y_W'(SPR_H - 1);
    if (state == S_CLEAR) begin
      col_last = X_W'(SCREEN_W - 1);
      row_last = Y_W'(SCREEN_H - 1);
    end
    sweeping   = (state == S_CLEAR) || (state == S_ERASE) || (state == S_DRAW);
    sweep_last = (col == col_last) && (row == row_last);
  end

  // Clamped move; sums are one bit wider so the clamp sees the true value.
  always_comb begin
    right_sum  = {1'b0, pos_x} + (X_W+1)'(STEP);
    down_sum   = {1'b0, pos_y} + (Y_W+1)'(STEP);
    pos_x_next = pos_x;
    pos_y_next = pos_y;
    if (move_right && !move_left) begin
      pos_x_next = (right_sum > (X_W+1)'(SCREEN_W - SPR_W)) ? X_W'(SCREEN_W - SPR_W)
                                                              : right_sum[X_W-1:0];
    end else if (move_left && !move_right) begin
      pos_x_next = (pos_x < X_W'(STEP)) ? '0 : pos_x - X_W'(STEP);
    end
    if (move_down && !move_up) begin
      pos_y_next = (down_sum > (Y_W+1)'(SCREEN_H - SPR_H)) ? Y_W'(SCREEN_H - SPR_H)
                                                             : down_sum[Y_W-1:0];
    end else if (move_up && !move_down) begin
      pos_y_next = (pos_y < Y_W'(STEP)) ? '0 : pos_y - Y_W'(STEP);
    end
  end

  always_comb begin
    state_next  = state;
    plot_next   = 1'b0;
    colour_next = BG_COLOUR;
    pix_x_next  = pos_x + col;
    pix_y_next  = pos_y + row;
    case (state)
      S_CLEAR: begin
        plot_next  = 1'b1;
        pix_x_next = col;
        pix_y_next = row;
        if (sweep_last) state_next = S_DRAW;
      end
      S_IDLE: begin
        if (frame_tick) state_next = S_ERASE;
      end
      S_ERASE: begin
        plot_next = 1'b1;
        if (sweep_last) state_next = S_UPDATE;
      end
      S_UPDATE: begin
        state_next = S_DRAW;
      end
      S_DRAW: begin
        plot_next   = 1'b1;
        colour_next = FG_COLOUR;
        if (sweep_last) state_next = S_IDLE;
      end
      default: begin
        state_next = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_CLEAR;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col     <= '0;
      row     <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= BG_COLOUR;
      plot    <= 1'b0;
      pos_x   <= X_W'(START_X);
      pos_y   <= Y_W'(START_Y);
      busy    <= 1'b1;
      overrun <= 1'b0;
    end else begin
      x      <= pix_x_next;
      y      <= pix_y_next;
      colour <= colour_next;
      plot   <= plot_next;
      busy   <= (state_next != S_IDLE);
      if (frame_tick && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
      if (state == S_UPDATE) begin
        pos_x <= pos_x_next;
        pos_y <= pos_y_next;
      end
      // Counters wrap to zero on the last pixel, ready for the next sweep.
      if (sweeping) begin
        if (col == col_last) begin
          col <= '0;
          row <= (row == row_last) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        col <= '0;
        row <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_move_engine.sv
// tb/tb_sprite_move_engine.sv - scoreboard bench for sprite_move_engine on a 16x8 screen
module tb_sprite_move_engine;

  localparam int SW = 16, SH = 8, SPW = 4, SPH = 2, SX = 6, SY = 5, FD = 100, FD2 = 10;
  localparam logic [2:0] FG = 3'b111, BG = 3'b000;

  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic       reset;
  logic       move_left, move_right, move_up, move_down;
  logic [7:0] x, pos_x, x_b, pos_x_b;
  logic [6:0] y, pos_y, y_b, pos_y_b;
  logic [2:0] colour, colour_b;
  logic       plot, busy, overrun, plot_b, busy_b, overrun_b;

  sprite_move_engine #(
    .SCREEN_W(SW), .SCREEN_H(SH), .X_W(8), .Y_W(7), .SPR_W(SPW), .SPR_H(SPH),
    .START_X(SX), .START_Y(SY), .STEP(1), .FRAME_DIV(FD), .FG_COLOUR(FG), .BG_COLOUR(BG)
  ) dut (
    .clock(CLOCK_50), .reset(reset),
    .move_left(move_left), .move_right(move_right), .move_up(move_up), .move_down(move_down),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .overrun(overrun)
  );

  sprite_move_engine #(
    .SCREEN_W(SW), .SCREEN_H(SH), .X_W(8), .Y_W(7), .SPR_W(SPW), .SPR_H(SPH),
    .START_X(SX), .START_Y(SY), .STEP(1), .FRAME_DIV(FD2), .FG_COLOUR(FG), .BG_COLOUR(BG)
  ) dut_fast (
    .clock(CLOCK_50), .reset(reset),
    .move_left(1'b0), .move_right(1'b0), .move_up(1'b0), .move_down(1'b0),
    .x(x_b), .y(y_b), .colour(colour_b), .plot(plot_b),
    .pos_x(pos_x_b), .pos_y(pos_y_b), .busy(busy_b), .overrun(overrun_b)
  );

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   mpx, mpy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_rect(input int ox, input int oy, input int w, input int h, input logic [2:0] c);
    for (int r = 0; r < h; r++)
      for (int k = 0; k < w; k++)
        exp_q.push_back('{px: 8'(ox + k), py: 7'(oy + r), pc: c});
  endtask

  function automatic int step_axis(input int p, input bit inc, input bit dec, input int maxp);
    if (inc && !dec) return (p + 1 > maxp) ? maxp : p + 1;
    if (dec && !inc) return (p < 1) ? 0 : p - 1;
    return p;
  endfunction

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (busy !== lvl) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: busy=%b after %0d cycles, wanted %b", name, busy, n, lvl);
    end
  endtask

  // Monitor: every plot strobe must match the next expected pixel.
  always @(negedge CLOCK_50) begin
    if (plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_plot: got (%0d,%0d,c%0d) expected none at %0t", x, y, colour, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("plot_x", 32'(x), 32'(mon_e.px));
        check("plot_y", 32'(y), 32'(mon_e.py));
        check("plot_colour", 32'(colour), 32'(mon_e.pc));
      end
    end
  end

  task automatic do_frame(input logic [3:0] mv);
    {move_left, move_right, move_up, move_down} = mv;
    push_rect(mpx, mpy, SPW, SPH, BG);
    mpx = step_axis(mpx, mv[2], mv[3], SW - SPW);
    mpy = step_axis(mpy, mv[0], mv[1], SH - SPH);
    push_rect(mpx, mpy, SPW, SPH, FG);
    wait_busy(1'b1, FD + 20, "tick_start");
    wait_busy(1'b0, 60, "frame_done");
    @(negedge CLOCK_50);
    check("pos_x", 32'(pos_x), 32'(mpx));
    check("pos_y", 32'(pos_y), 32'(mpy));
    check("frame_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  logic [3:0] ph_mv  [9] = '{4'b0100, 4'b0100, 4'b1100, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b1000, 4'b0011};
  int         ph_cnt [9] = '{1, 6, 2, 1, 2, 7, 1, 13, 1};

  initial begin
    #(20 * 20000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    {move_left, move_right, move_up, move_down} = 4'b0000;
    repeat (3) @(negedge CLOCK_50);
    check("reset_plot", 32'(plot), 32'd0);
    check("reset_x", 32'(x), 32'd0);
    check("reset_y", 32'(y), 32'd0);
    check("reset_colour", 32'(colour), 32'(BG));
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_pos_x", 32'(pos_x), 32'(SX));
    check("reset_pos_y", 32'(pos_y), 32'(SY));

    mpx = SX;
    mpy = SY;
    push_rect(0, 0, SW, SH, BG);
    push_rect(mpx, mpy, SPW, SPH, FG);
    reset = 1'b0;

    repeat (5) @(negedge CLOCK_50);
    check("fast_overrun_before_tick", 32'(overrun_b), 32'd0);
    repeat (15) @(negedge CLOCK_50);
    check("fast_overrun_after_tick", 32'(overrun_b), 32'd1);

    wait_busy(1'b0, 400, "init_done");
    @(negedge CLOCK_50);
    check("init_queue_empty", 32'(exp_q.size()), 32'd0);
    check("init_pos_x", 32'(pos_x), 32'(SX));
    check("init_pos_y", 32'(pos_y), 32'(SY));
    check("init_overrun", 32'(overrun), 32'((FD < SW * SH + SPW * SPH) ? 1 : 0));

    for (int p = 0; p < 9; p++) begin
      for (int i = 0; i < ph_cnt[p]; i++) do_frame(ph_mv[p]);
      if (p == 0) check("right_step_x", 32'(pos_x), 32'd7);
      if (p == 2) check("right_clamp_x", 32'(pos_x), 32'd12);
      if (p == 3) check("down_step_y", 32'(pos_y), 32'd6);
      if (p == 6) check("up_clamp_y", 32'(pos_y), 32'd0);
    end
    check("fast_overrun_sticky", 32'(overrun_b), 32'd1);

    for (int i = 0; i < 25; i++) do_frame(4'($urandom_range(0, 15)));

    // Reset while the third DRAW pixel is on the bus.
    {move_left, move_right, move_up, move_down} = 4'b0000;
    push_rect(mpx, mpy, SPW, SPH, BG);
    push_rect(mpx, mpy, 3, 1, FG);
    wait_busy(1'b1, FD + 20, "mid_tick_start");
    n = 0;
    do begin
      @(negedge CLOCK_50);
      #1;
      n++;
    end while (exp_q.size() != 0 && n < 60);
    check("mid_third_pixel_on", 32'(plot), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_plot", 32'(plot), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd1);
    check("mid_reset_x", 32'(x), 32'd0);
    check("mid_reset_pos_x", 32'(pos_x), 32'(SX));
    check("mid_reset_pos_y", 32'(pos_y), 32'(SY));
    check("mid_reset_overrun", 32'(overrun), 32'd0);
    check("mid_reset_fast_overrun", 32'(overrun_b), 32'd0);

    mpx = SX;
    mpy = SY;
    push_rect(0, 0, SW, SH, BG);
    push_rect(mpx, mpy, SPW, SPH, FG);
    @(negedge CLOCK_50);
    reset = 1'b0;
    wait_busy(1'b0, 400, "reclear_done");
    @(negedge CLOCK_50);
    check("reclear_queue_empty", 32'(exp_q.size()), 32'd0);
    check("reclear_pos_x", 32'(pos_x), 32'(SX));
    check("fast_overrun_after_rerun", 32'(overrun_b), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
